// File: rtl/m_fetch_buffer_unit.sv
// Fetch unit: owns the fetch PC, keeps up to DEPTH MMU requests in flight and queues returned
// instructions for decode. Optional per-entry fault tracking under `FETCH_FAULT_EN.
module m_fetch_buffer_unit #(
  parameter int unsigned     XLEN     = 32,
  parameter int unsigned     DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = 32'h8000_0000
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            if_stall_in,
  input  logic            csr_pc_req_in,
  input  logic [XLEN-1:0] csr_pc_in,
  input  logic            exe_pc_req_in,
  input  logic [XLEN-1:0] exe_pc_in,
  output logic            i_req,
  output logic [XLEN-1:0] i_vaddr,
  input  logic            i_gnt,
  output logic            i_kill,
  input  logic            i_rvalid,
  input  logic [XLEN-1:0] i_paddr,
`ifdef FETCH_FAULT_EN
  input  logic            i_fault_in,
  output logic            dec_fault_o,
`endif
  output logic            dec_valid_o,
  input  logic            dec_ready_in,
  output logic [XLEN-1:0] instruction_o,
  output logic [XLEN-1:0] dec_pc_o
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH + 1);

  typedef logic [PW-1:0] ptr_t;
  typedef logic [CW-1:0] cnt_t;

  logic [XLEN-1:0] pc_q, pc_d;
  ptr_t            head_q, head_d, alloc_q, alloc_d, fill_q, fill_d;
  cnt_t            reserved_q, reserved_d, pending_q, pending_d, drop_q, drop_d;
  logic [XLEN-1:0] ent_pc_q   [DEPTH];
  logic [XLEN-1:0] ent_pc_d   [DEPTH];
  logic [XLEN-1:0] ent_data_q [DEPTH];
  logic [XLEN-1:0] ent_data_d [DEPTH];
  logic [DEPTH-1:0] ent_full_q, ent_full_d;
`ifdef FETCH_FAULT_EN
  logic [DEPTH-1:0] ent_fault_q, ent_fault_d;
  logic             fault_halt_q, fault_halt_d;
`endif

  logic            redirect;
  logic [XLEN-1:0] redirect_pc;
  logic            credit_ok;
  logic            grant;
  logic            pop;
  logic            drop_rsp;
  logic            fill;

  always_comb begin
    redirect    = csr_pc_req_in | exe_pc_req_in;
    redirect_pc = csr_pc_req_in ? csr_pc_in : exe_pc_in;
    credit_ok   = ({1'b0, reserved_q} + {1'b0, drop_q}) < (CW + 1)'(DEPTH);
    i_req       = rst_n && !if_stall_in && !redirect && credit_ok;
`ifdef FETCH_FAULT_EN
    i_req       = i_req && !fault_halt_q;
`endif
    i_vaddr     = i_req ? pc_q : '0;
    i_kill      = redirect;
    grant       = i_req && i_gnt;
    dec_valid_o = ent_full_q[head_q] && !redirect;
    pop         = dec_valid_o && dec_ready_in;
    // Every response in a redirect cycle belongs to the old path.
    drop_rsp    = i_rvalid && (redirect || (drop_q != '0));
    fill        = i_rvalid && !drop_rsp;
    instruction_o = ent_data_q[head_q];
    dec_pc_o      = ent_pc_q[head_q];
`ifdef FETCH_FAULT_EN
    dec_fault_o   = ent_fault_q[head_q];
`endif
  end

  always_comb begin
    pc_d       = pc_q;
    head_d     = head_q;
    alloc_d    = alloc_q;
    fill_d     = fill_q;
    reserved_d = reserved_q;
    pending_d  = pending_q;
    drop_d     = drop_q;
    ent_pc_d   = ent_pc_q;
    ent_data_d = ent_data_q;
    ent_full_d = ent_full_q;
`ifdef FETCH_FAULT_EN
    ent_fault_d  = ent_fault_q;
    fault_halt_d = fault_halt_q;
`endif
    if (redirect) begin
      pc_d       = {redirect_pc[XLEN-1:2], 2'b00};
      ent_full_d = '0;
      alloc_d    = head_q;
      fill_d     = head_q;
      reserved_d = '0;
      pending_d  = '0;
      // Outstanding old-path requests become drops, minus one returning right now.
      drop_d     = drop_q + pending_q - cnt_t'(i_rvalid);
`ifdef FETCH_FAULT_EN
      fault_halt_d = 1'b0;
`endif
    end else begin
      if (grant) begin
        ent_pc_d[alloc_q]   = pc_q;
        ent_full_d[alloc_q] = 1'b0;
        alloc_d             = alloc_q + ptr_t'(1);
        pc_d                = pc_q + XLEN'(4);
      end
      if (fill) begin
        ent_data_d[fill_q] = i_paddr;
        ent_full_d[fill_q] = 1'b1;
        fill_d             = fill_q + ptr_t'(1);
`ifdef FETCH_FAULT_EN
        ent_fault_d[fill_q] = i_fault_in;
        if (i_fault_in) fault_halt_d = 1'b1;
`endif
      end
      if (drop_rsp) drop_d = drop_q - cnt_t'(1);
      if (pop) begin
        ent_full_d[head_q] = 1'b0;
        head_d             = head_q + ptr_t'(1);
      end
      reserved_d = reserved_q + cnt_t'(grant) - cnt_t'(pop);
      pending_d  = pending_q + cnt_t'(grant) - cnt_t'(fill);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q       <= RESET_PC;
      head_q     <= '0;
      alloc_q    <= '0;
      fill_q     <= '0;
      reserved_q <= '0;
      pending_q  <= '0;
      drop_q     <= '0;
      ent_full_q <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        ent_pc_q[i]   <= '0;
        ent_data_q[i] <= '0;
      end
`ifdef FETCH_FAULT_EN
      ent_fault_q  <= '0;
      fault_halt_q <= 1'b0;
`endif
    end else begin
      pc_q       <= pc_d;
      head_q     <= head_d;
      alloc_q    <= alloc_d;
      fill_q     <= fill_d;
      reserved_q <= reserved_d;
      pending_q  <= pending_d;
      drop_q     <= drop_d;
      ent_full_q <= ent_full_d;
      ent_pc_q   <= ent_pc_d;
      ent_data_q <= ent_data_d;
`ifdef FETCH_FAULT_EN
      ent_fault_q  <= ent_fault_d;
      fault_halt_q <= fault_halt_d;
`endif
    end
  end

endmodule

// File: doc/m_fetch_buffer_unit.md
Name: m_fetch_buffer_unit

Overview:
- Parametrised successor to the combinational instruction fetcher.
- Owns the fetch PC. Issues in-order requests to the MMU with a grant handshake and can keep several requests in flight.
- Buffers returned instructions with their PCs in a DEPTH-entry queue and presents them to decode with a valid/ready handshake.
- On a CSR or EXE redirect: kills and flushes the queue, then silently drops stale MMU responses.

Parameters:
- XLEN, 32, width of PC, addresses and instruction word
- DEPTH, 4, queue entries and maximum in-flight requests (power of 2, ≥2)
- RESET_PC, 32'h8000_0000, fetch PC after reset

Ports:
- clk  in  1  clock; all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- if_stall_in  in  1  hazard unit: suppress new issue
- csr_pc_req_in  in  1  CSR redirect request
- csr_pc_in  in  XLEN  CSR redirect target
- exe_pc_req_in  in  1  EXE (branch/jump) redirect request
- exe_pc_in  in  XLEN  EXE redirect target
- i_req  out  1  fetch request to MMU
- i_vaddr  out  XLEN  request virtual address; 0 when i_req=0
- i_gnt  in  1  MMU accepts request this cycle
- i_kill  out  1  kill in-flight MMU work
- i_rvalid  in  1  MMU response valid (in order, one per granted req)
- i_paddr  in  XLEN  returned instruction word
- dec_valid_o  out  1  instruction valid to decode
- dec_ready_in  in  1  decode accepts
- instruction_o  out  XLEN  instruction at queue head
- dec_pc_o  out  XLEN  PC of that instruction

Behaviour:
- Reset (async assert, sync deassert use):
  - pc_q=RESET_PC; queue empty (head/alloc/fill pointers=0); reserved_cnt=0; drop_cnt=0.
  - Outputs: i_req=0, i_vaddr=0, dec_valid_o=0, instruction_o=0, dec_pc_o=0.
- Redirect:
  - redirect = csr_pc_req_in | exe_pc_req_in.
  - i_kill = redirect (combinational, same cycle).
  - When both requests are high, CSR wins.
- Issue:
  - i_req = !if_stall_in && !redirect && (reserved_cnt + drop_cnt < DEPTH).
  - i_vaddr = pc_q when i_req, else 0.
- Grant (i_req && i_gnt):
  - Allocate the entry at alloc_ptr: store pc_q, mark data-empty.
  - alloc_ptr++, reserved_cnt++, pc_q += 4 (mod 2^XLEN wrap).
  - i_req held without i_gnt: pc_q and i_vaddr stay stable.
- Response (i_rvalid):
  - If drop_cnt>0: discard the response, drop_cnt--.
  - Else: write i_paddr into the entry at fill_ptr, set its data-full bit, fill_ptr++.
  - A response with no outstanding request is an MMU protocol error; the design need not handle it.
- Decode output:
  - dec_valid_o = head entry data-full && !redirect; instruction_o/dec_pc_o come from the head entry.
  - Pop on dec_valid_o && dec_ready_in: head_ptr++, reserved_cnt--.
  - Zero-latency bypass is not provided: an instruction is visible to decode the cycle after i_rvalid.
- Redirect cycle, effects at the clock edge:
  - pc_q <= selected target with bits[1:0] cleared.
  - All queue entries are invalidated; head, alloc and fill pointers are set equal.
  - reserved_cnt <= 0.
  - drop_cnt <= drop_cnt + (granted-but-unreturned count) − (1 if an i_rvalid was consumed this cycle as a drop).
  - An i_rvalid in the redirect cycle belongs to the old path and is always dropped/counted.
  - No pop and no grant in the redirect cycle.
- First issue after a redirect occurs the next cycle.
  - Stale responses are dropped while new-path requests issue.
  - The credit rule keeps total in-flight ≤ DEPTH.
- Full: reserved_cnt + drop_cnt == DEPTH gives i_req=0. Pop and grant in the same cycle keep the count constant.
- Empty: dec_valid_o=0. Pointers wrap modulo DEPTH.
- if_stall_in: blocks issue only. Responses still fill and decode may still pop.
- Reset mid-operation: returns to the reset state immediately. The MMU is reset by the same rst_n.

Optional Feature:
- Macro FETCH_FAULT_EN.
- When defined:
  - Adds port i_fault_in (in, 1), sampled with i_rvalid and stored per entry.
  - Adds port dec_fault_o (out, 1), the fault bit of the head entry, reset 0.
  - A faulting entry still pops normally. Issue halts after a fault is filled, until a redirect.
  - Dropped responses ignore i_fault_in.
- When undefined: neither port exists and there is no fault state.

Test Plan:
- Reset release, if_stall_in=0, i_gnt=1, 1-cycle MMU latency:
  - Expect i_vaddr 0x8000_0000, 0x8000_0004, 0x8000_0008…
  - dec_pc_o follows the same sequence with the matching instruction_o.
- dec_ready_in=0, MMU always returning (DEPTH=4):
  - Exactly 4 grants, then i_req=0.
  - After one pop, exactly one more request, at 0x8000_0010.
- Two requests in flight, exe_pc_req_in=1 with exe_pc_in=0x8000_0102:
  - i_kill=1 that cycle; next i_vaddr=0x8000_0100.
  - The 2 old responses are dropped; the first decoded pc is 0x8000_0100.
- csr_pc_req_in and exe_pc_req_in together with targets 0x100/0x200: fetch resumes at 0x100.
- i_gnt held low 3 cycles with if_stall_in toggling:
  - i_vaddr is stable while requested and 0 while stalled.
  - pc_q does not advance until the grant.
- FETCH_FAULT_EN, fault on the 2nd response:
  - dec_fault_o=1 with dec_pc_o=0x8000_0004.
  - No further i_req until a redirect.
